// File: rtl/matrix_store_unit.sv
// -----------------------------------------------------------------------------
// matrix_store_unit
//
// Store path of the matrix LSU. Accepts one store instruction at a time, waits
// until the rw queue hands read permission to that instruction's id, then for
// each row reads the source matrix register over RF port LSU_R and writes the
// row to memory at addr + row*stride. The RF port is released as soon as the
// last row is granted on the bus; completion is signalled once every bus write
// response has come back.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   instr_*                store instruction handshake (valid/ready) + fields
//   conf_n_col_bytes_i     bytes per row to store (clamped to RLEN/8)
//   conf_n_rows_i          rows to store (clamped to N_ROWS)
//   perm_rvalid_i/perm_id_i  read permission from the rw queue
//   rf_req_o/rf_reg_o/rf_row_o/rf_rdata_i  RF read port (data one cycle later)
//   rf_release_o/rf_release_id_o           one-cycle read-port release pulse
//   data_*                 memory bus write request/grant/response
//   done_valid_o/done_id_o one-cycle completion pulse
// -----------------------------------------------------------------------------
module matrix_store_unit #(
  parameter int N_REGS    = 8,
  parameter int N_ROWS    = 4,
  parameter int RLEN      = 128,
  parameter int BUS_WIDTH = 128,
  parameter int ID_WIDTH  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [31:0]               instr_addr_i,
  input  logic [31:0]               instr_stride_i,
  input  logic [$clog2(N_REGS)-1:0] instr_reg_i,
  input  logic [ID_WIDTH-1:0]       instr_id_i,
  input  logic [31:0]               conf_n_col_bytes_i,
  input  logic [31:0]               conf_n_rows_i,
  input  logic                      perm_rvalid_i,
  input  logic [ID_WIDTH-1:0]       perm_id_i,
  output logic                      rf_req_o,
  output logic [$clog2(N_REGS)-1:0] rf_reg_o,
  output logic [$clog2(N_ROWS)-1:0] rf_row_o,
  input  logic [RLEN-1:0]           rf_rdata_i,
  output logic                      rf_release_o,
  output logic [ID_WIDTH-1:0]       rf_release_id_o,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  output logic                      data_we_o,
  output logic [31:0]               data_addr_o,
  output logic [BUS_WIDTH/8-1:0]    data_be_o,
  output logic [BUS_WIDTH-1:0]      data_wdata_o,
  input  logic                      data_rvalid_i,
  output logic                      done_valid_o,
  output logic [ID_WIDTH-1:0]       done_id_o
);

  localparam int REG_W = $clog2(N_REGS);
  localparam int ROW_W = $clog2(N_ROWS);
  localparam int CNT_W = ROW_W + 1;            // holds 0..N_ROWS
  localparam int NB_W  = $clog2(RLEN / 8) + 1; // holds 0..RLEN/8
  localparam int BE_W  = BUS_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PERM,
    S_READ,
    S_CAPTURE,
    S_REQ,
    S_RELEASE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_cur_q, addr_cur_d;
  logic [31:0]          stride_q, stride_d;
  logic [REG_W-1:0]     reg_q, reg_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [CNT_W-1:0]     nr_q, nr_d;
  logic [NB_W-1:0]      nb_q, nb_d;
  logic [CNT_W-1:0]     row_q, row_d;
  logic [CNT_W-1:0]     out_q, out_d;
  logic [RLEN-1:0]      wbuf_q, wbuf_d;

  logic                 grant_s;
  logic [CNT_W-1:0]     nr_clamp_s;
  logic [NB_W-1:0]      nb_clamp_s;

  // Byte-enable mask with the low n bytes set.
  function automatic logic [BE_W-1:0] low_byte_mask(input logic [NB_W-1:0] n);
    logic [BE_W-1:0] m;
    for (int i = 0; i < BE_W; i++) begin
      m[i] = (NB_W'(i) < n);
    end
    return m;
  endfunction

  assign grant_s    = (state_q == S_REQ) && data_gnt_i;
  assign nr_clamp_s = (conf_n_rows_i >= 32'(N_ROWS)) ? CNT_W'(N_ROWS)
                                                      : conf_n_rows_i[CNT_W-1:0];
  assign nb_clamp_s = (conf_n_col_bytes_i >= 32'(RLEN / 8)) ? NB_W'(RLEN / 8)
                                                             : conf_n_col_bytes_i[NB_W-1:0];

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_cur_q <= 32'd0;
      stride_q   <= 32'd0;
      reg_q      <= '0;
      id_q       <= '0;
      nr_q       <= '0;
      nb_q       <= '0;
      row_q      <= '0;
      out_q      <= '0;
      wbuf_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_cur_q <= addr_cur_d;
      stride_q   <= stride_d;
      reg_q      <= reg_d;
      id_q       <= id_d;
      nr_q       <= nr_d;
      nb_q       <= nb_d;
      row_q      <= row_d;
      out_q      <= out_d;
      wbuf_q     <= wbuf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    addr_cur_d = addr_cur_q;
    stride_d   = stride_q;
    reg_d      = reg_q;
    id_d       = id_q;
    nr_d       = nr_q;
    nb_d       = nb_q;
    row_d      = row_q;
    wbuf_d     = wbuf_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid_i) begin
          addr_cur_d = instr_addr_i;
          stride_d   = instr_stride_i;
          reg_d      = instr_reg_i;
          id_d       = instr_id_i;
          nr_d       = nr_clamp_s;
          nb_d       = nb_clamp_s;
          row_d      = '0;
          state_d    = S_WAIT_PERM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_PERM: begin
        if (perm_rvalid_i && (perm_id_i == id_q)) begin
          // Nothing to move: hand the port straight back.
          if ((nr_q == '0) || (nb_q == '0)) begin
            state_d = S_RELEASE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_WAIT_PERM;
        end
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        wbuf_d  = rf_rdata_i;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (data_gnt_i) begin
          row_d      = row_q + CNT_W'(1);
          addr_cur_d = addr_cur_q + stride_q;
          if ((row_q + CNT_W'(1)) == nr_q) begin
            state_d = S_RELEASE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_RELEASE: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outstanding write responses; a response with nothing outstanding is dropped.
  always_comb begin
    if (grant_s && !data_rvalid_i) begin
      out_d = out_q + CNT_W'(1);
    end else if (data_rvalid_i && !grant_s && (out_q != '0)) begin
      out_d = out_q - CNT_W'(1);
    end else begin
      out_d = out_q;
    end
  end

  // Moore outputs decoded from the state register; idle values are zero.
  always_comb begin
    instr_ready_o   = (state_q == S_IDLE);
    rf_req_o        = 1'b0;
    rf_reg_o        = '0;
    rf_row_o        = '0;
    rf_release_o    = 1'b0;
    rf_release_id_o = '0;
    data_req_o      = 1'b0;
    data_we_o       = 1'b0;
    data_addr_o     = 32'd0;
    data_be_o       = '0;
    data_wdata_o    = '0;
    done_valid_o    = 1'b0;
    done_id_o       = '0;

    case (state_q)
      S_READ: begin
        rf_req_o = 1'b1;
        rf_reg_o = reg_q;
        rf_row_o = row_q[ROW_W-1:0];
      end
      S_REQ: begin
        data_req_o   = 1'b1;
        data_we_o    = 1'b1;
        data_addr_o  = addr_cur_q;
        data_be_o    = low_byte_mask(nb_q);
        data_wdata_o = wbuf_q; // RLEN == BUS_WIDTH
      end
      S_RELEASE: begin
        rf_release_o    = 1'b1;
        rf_release_id_o = id_q;
      end
      S_DONE: begin
        done_valid_o = 1'b1;
        done_id_o    = id_q;
      end
      default: begin
        rf_req_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_matrix_store_unit.sv
module tb_matrix_store_unit;

  localparam int N_REGS = 8;
  localparam int N_ROWS = 4;
  localparam int RLEN   = 128;
  localparam int BW     = 128;
  localparam int IDW    = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             instr_valid_i;
  logic             instr_ready_o;
  logic [31:0]      instr_addr_i;
  logic [31:0]      instr_stride_i;
  logic [2:0]       instr_reg_i;
  logic [IDW-1:0]   instr_id_i;
  logic [31:0]      conf_n_col_bytes_i;
  logic [31:0]      conf_n_rows_i;
  logic             perm_rvalid_i;
  logic [IDW-1:0]   perm_id_i;
  logic             rf_req_o;
  logic [2:0]       rf_reg_o;
  logic [1:0]       rf_row_o;
  logic [RLEN-1:0]  rf_rdata_i;
  logic             rf_release_o;
  logic [IDW-1:0]   rf_release_id_o;
  logic             data_req_o;
  logic             data_gnt_i;
  logic             data_we_o;
  logic [31:0]      data_addr_o;
  logic [BW/8-1:0]  data_be_o;
  logic [BW-1:0]    data_wdata_o;
  logic             data_rvalid_i;
  logic             done_valid_o;
  logic [IDW-1:0]   done_id_o;

  matrix_store_unit #(
    .N_REGS(N_REGS), .N_ROWS(N_ROWS), .RLEN(RLEN), .BUS_WIDTH(BW), .ID_WIDTH(IDW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_addr_i(instr_addr_i), .instr_stride_i(instr_stride_i),
    .instr_reg_i(instr_reg_i), .instr_id_i(instr_id_i),
    .conf_n_col_bytes_i(conf_n_col_bytes_i), .conf_n_rows_i(conf_n_rows_i),
    .perm_rvalid_i(perm_rvalid_i), .perm_id_i(perm_id_i),
    .rf_req_o(rf_req_o), .rf_reg_o(rf_reg_o), .rf_row_o(rf_row_o),
    .rf_rdata_i(rf_rdata_i),
    .rf_release_o(rf_release_o), .rf_release_id_o(rf_release_id_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
    .data_addr_o(data_addr_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i),
    .done_valid_o(done_valid_o), .done_id_o(done_id_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file contents and bus responder knobs
  logic [127:0] rf_mem [N_REGS][N_ROWS];
  int  pend = 0, wait_cnt = 0, cur_delay = 0, gnt_min = 0, gnt_max = 0;
  bit  gnt_block = 0, rsp_allow = 1, rsp_rand = 0, force_rsp = 0;
  bit  rd_pend = 0;
  int  rd_reg = 0, rd_row = 0;

  // RF read port and memory bus responder, driven on the falling edge
  initial begin
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    rf_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (rf_req_o) begin
        rf_rdata_i = {$urandom, $urandom, $urandom, $urandom};
        rd_pend = 1; rd_reg = int'(rf_reg_o); rd_row = int'(rf_row_o);
      end else if (rd_pend) begin
        rf_rdata_i = rf_mem[rd_reg][rd_row];
        rd_pend = 0;
      end else begin
        rf_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
      if (!rst_ni) begin
        pend = 0; wait_cnt = 0;
      end else begin
        if (force_rsp) data_rvalid_i = 1'b1;
        else if (pend > 0 && rsp_allow && (!rsp_rand || $urandom_range(0, 2) == 0)) begin
          data_rvalid_i = 1'b1; pend--;
        end
        if (data_req_o && !gnt_block) begin
          if (wait_cnt >= cur_delay) begin
            data_gnt_i = 1'b1; pend++; wait_cnt = 0;
            cur_delay = $urandom_range(gnt_min, gnt_max);
          end else wait_cnt++;
        end
      end
    end
  end

  // Behavioural model state: what the current instruction must produce
  logic [31:0]  m_addr  [N_ROWS];
  logic [127:0] m_wdata [N_ROWS];
  logic [15:0]  m_be;
  logic [2:0]   m_reg;
  logic [3:0]   m_id;
  int  m_eff = 0, m_rows = 0, m_out = 0, m_out_last = 0;
  bit  m_busy = 0, m_perm = 0, m_in_drain = 0, m_rel_last = 0;
  int  n_grants = 0, n_release = 0, n_done = 0, cyc = 0;

  // Compare process: sample #1 after each rising edge
  initial begin : compare
    bit grant, rsp, perm_edge, exp_rf, exp_req, exp_rel, exp_done;
    bit prev_ready, prev_req, rf1, rf2;
    logic [31:0] prev_addr;
    int nr, nb, ri;
    prev_ready = 1; prev_req = 0; rf1 = 0; rf2 = 0; prev_addr = 32'd0;
    forever begin
      @(posedge clk_i); #1; cyc++;
      if (!rst_ni) begin
        chk("rst_ready", instr_ready_o, 1);
        chk("rst_rf_req", rf_req_o, 0);
        chk("rst_data_req", data_req_o, 0);
        chk("rst_release", rf_release_o, 0);
        chk("rst_done", done_valid_o, 0);
        chk("rst_addr", data_addr_o, 0);
        m_busy = 0; m_perm = 0; m_out = 0; m_out_last = 0; m_in_drain = 0; m_rel_last = 0;
        prev_ready = 1; prev_req = 0; rf1 = 0; rf2 = 0;
      end else begin
        grant = prev_req && data_gnt_i;
        rsp = data_rvalid_i;
        perm_edge = 0;
        if (m_busy && !m_perm && perm_rvalid_i && perm_id_i == m_id) begin
          m_perm = 1; perm_edge = 1;
        end
        if (grant) begin m_rows++; n_grants++; end
        if (grant && !rsp) m_out++;
        else if (rsp && !grant && m_out > 0) m_out--;
        if (prev_ready && instr_valid_i) begin
          nr = (conf_n_rows_i > 32'd4) ? 4 : int'(conf_n_rows_i);
          nb = (conf_n_col_bytes_i > 32'd16) ? 16 : int'(conf_n_col_bytes_i);
          m_eff = (nb == 0) ? 0 : nr;
          m_be = 16'((32'd1 << nb) - 32'd1);
          m_reg = instr_reg_i; m_id = instr_id_i;
          for (int i = 0; i < N_ROWS; i++) begin
            m_addr[i] = instr_addr_i + 32'(i) * instr_stride_i;
            m_wdata[i] = rf_mem[instr_reg_i][i];
          end
          m_busy = 1; m_perm = 0; m_rows = 0;
        end
        exp_rf   = (perm_edge && m_eff > 0) || (grant && m_rows < m_eff);
        exp_req  = rf2 || (prev_req && !grant);
        exp_rel  = (perm_edge && m_eff == 0) || (grant && m_rows == m_eff);
        exp_done = m_in_drain && (m_out_last == 0);
        ri = (m_rows < N_ROWS) ? m_rows : 0;

        chk("ready", instr_ready_o, !m_busy);
        chk("rf_req", rf_req_o, exp_rf);
        if (exp_rf) begin
          chk("rf_reg", rf_reg_o, m_reg);
          chk("rf_row", rf_row_o, m_rows);
        end
        chk("data_req", data_req_o, exp_req);
        if (exp_req) begin
          chk("data_we", data_we_o, 1);
          chk("data_addr", data_addr_o, m_addr[ri]);
          chk("data_be", data_be_o, m_be);
          chk("data_wdata", data_wdata_o, m_wdata[ri]);
          if (prev_req) chk("addr_stable", data_addr_o, prev_addr);
        end
        chk("release", rf_release_o, exp_rel);
        if (exp_rel) chk("release_id", rf_release_id_o, m_id);
        if (rf_release_o) n_release++;
        chk("done", done_valid_o, exp_done);
        if (exp_done) chk("done_id", done_id_o, m_id);
        if (done_valid_o) n_done++;

        if (exp_done) begin m_in_drain = 0; m_busy = 0; end
        if (m_rel_last) m_in_drain = 1;
        m_rel_last = exp_rel;
        m_out_last = m_out;
        rf2 = rf1; rf1 = exp_rf;
        prev_req = data_req_o; prev_addr = data_addr_o; prev_ready = instr_ready_o;
      end
    end
  end

  int base_done = 0, base_rel = 0, base_gnt = 0;

  task automatic issue(input logic [31:0] a, input logic [31:0] s, input int rg, input int id,
                       input int ncol, input int nrows, input int stall);
    int to;
    logic [31:0] idv;
    idv = 32'(id);
    base_done = n_done; base_rel = n_release; base_gnt = n_grants;
    @(negedge clk_i);
    to = 0;
    while (!instr_ready_o && to < 200) begin @(negedge clk_i); to++; end
    if (to >= 200) chk("issue_ready_timeout", 0, 1);
    instr_valid_i = 1'b1; instr_addr_i = a; instr_stride_i = s;
    instr_reg_i = 3'(rg); instr_id_i = idv[3:0];
    conf_n_col_bytes_i = 32'(ncol); conf_n_rows_i = 32'(nrows);
    @(negedge clk_i);
    instr_valid_i = 1'b0; instr_addr_i = $urandom; instr_stride_i = $urandom;
    instr_reg_i = 3'($urandom); instr_id_i = 4'($urandom);
    conf_n_col_bytes_i = $urandom; conf_n_rows_i = $urandom;
    if (stall > 0) begin
      perm_rvalid_i = 1'b1; perm_id_i = 4'(idv[3:0] + 4'd11);
      repeat (stall) @(negedge clk_i);
    end
    perm_rvalid_i = 1'b1; perm_id_i = idv[3:0];
    @(negedge clk_i);
    perm_rvalid_i = 1'b0; perm_id_i = 4'($urandom);
  endtask

  task automatic finish_instr(input int exp_writes, input bit late);
    int to, trel;
    to = 0; trel = -1;
    while (n_done == base_done && to < 3000) begin
      @(negedge clk_i); to++;
      if (n_done != base_done) break;
      instr_valid_i = !instr_ready_o && ($urandom_range(0, 3) == 0);
      instr_addr_i = $urandom; instr_id_i = 4'($urandom);
      if (late && trel < 0 && n_release > base_rel) trel = cyc;
      if (late && trel >= 0 && !rsp_allow && (cyc - trel) >= 20) rsp_allow = 1;
    end
    instr_valid_i = 1'b0;
    chk("done_count", n_done - base_done, 1);
    chk("release_count", n_release - base_rel, 1);
    chk("write_count", n_grants - base_gnt, exp_writes);
    if (late) chk("release_to_done_ge20", (trel >= 0) && ((cyc - trel) >= 20), 1);
  endtask

  initial begin : stim
    int to, nr, nb, ew;
    instr_valid_i = 0; instr_addr_i = 0; instr_stride_i = 0; instr_reg_i = 0; instr_id_i = 0;
    conf_n_col_bytes_i = 0; conf_n_rows_i = 0; perm_rvalid_i = 0; perm_id_i = 0;
    for (int r = 0; r < N_REGS; r++)
      for (int w = 0; w < N_ROWS; w++)
        rf_mem[r][w] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic store
    issue(32'h1000, 32'h40, 3, 5, 16, 4, 0);
    chk("model_addr1", m_addr[1], 32'h1040);
    chk("model_addr3", m_addr[3], 32'h10C0);
    chk("model_be_full", m_be, 16'hFFFF);
    finish_instr(4, 0);

    // Partial rows/bytes, then clamped config
    issue(32'h2004, 32'h10, 1, 9, 6, 2, 0);
    chk("model_be_6", m_be, 16'h003F);
    finish_instr(2, 0);
    issue(32'h2100, 32'h80, 2, 3, 40, 9, 0);
    chk("model_clamp_rows", m_eff, 4);
    chk("model_clamp_be", m_be, 16'hFFFF);
    finish_instr(4, 0);

    // Permission stall on a foreign id
    issue(32'h3000, 32'h20, 6, 7, 16, 4, 10);
    finish_instr(4, 0);

    // Grant backpressure and late responses
    gnt_min = 5; gnt_max = 5; cur_delay = 5; rsp_allow = 0;
    issue(32'h4000, 32'h100, 4, 12, 16, 4, 0);
    finish_instr(4, 1);
    gnt_min = 0; gnt_max = 0; cur_delay = 0; rsp_allow = 1;

    // Degenerate sizes
    issue(32'h5000, 32'h40, 0, 1, 16, 0, 0);
    chk("model_zero_rows", m_eff, 0);
    finish_instr(0, 0);
    issue(32'h5000, 32'h40, 0, 2, 0, 3, 0);
    finish_instr(0, 0);

    // Address wrap
    issue(32'hFFFFFFC0, 32'h40, 5, 14, 16, 2, 0);
    chk("model_wrap_addr", m_addr[1], 32'h0);
    finish_instr(2, 0);

    // Reset in REQ with one write outstanding
    rsp_allow = 0;
    issue(32'h6000, 32'h20, 2, 4, 16, 4, 0);
    to = 0;
    while (n_grants == base_gnt && to < 100) begin @(negedge clk_i); to++; end
    gnt_block = 1;
    while (!data_req_o && to < 200) begin @(negedge clk_i); to++; end
    chk("reset_setup_req", data_req_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_ready", instr_ready_o, 1);
    chk("async_rst_data_req", data_req_o, 0);
    chk("async_rst_wdata", data_wdata_o, 0);
    chk("async_rst_be", data_be_o, 0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1; gnt_block = 0; rsp_allow = 1;
    @(negedge clk_i); force_rsp = 1;
    @(negedge clk_i); force_rsp = 0;
    repeat (2) @(negedge clk_i);
    issue(32'h7000, 32'h40, 3, 6, 16, 4, 0);
    finish_instr(4, 0);

    // Randomized traffic
    rsp_rand = 1;
    for (int k = 0; k < 30; k++) begin
      gnt_min = 0; gnt_max = $urandom_range(0, 3);
      nr = $urandom_range(0, 6); nb = $urandom_range(0, 20);
      ew = (nb == 0) ? 0 : ((nr > 4) ? 4 : nr);
      issue($urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255)),
            $urandom_range(0, 7), $urandom_range(0, 15), nb, nr, $urandom_range(0, 3));
      finish_instr(ew, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
